// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants one of NUM_SRC result sources per cycle and
// presents a single registered write to the register-file port.
module wb_arbiter #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned RR_MODE      = 1,
  parameter int unsigned ZERO_DISCARD = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic [NUM_SRC*DATA_W-1:0]    src_data,
  input  logic [NUM_SRC*ADDR_W-1:0]    src_addr,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [ADDR_W-1:0]            wb_addr,
  output logic [DATA_W-1:0]            wb_data,
  output logic [$clog2(NUM_SRC)-1:0]   wb_src,
  output logic [15:0]                  wb_count
);

  localparam int unsigned SRC_W = $clog2(NUM_SRC);
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [SRC_W-1:0]    r_ptr, w_ptr_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic [SRC_W-1:0]    r_src, w_src_nxt;
  logic [CNT_W-1:0]    r_count, w_count_nxt;

  logic [NUM_SRC-1:0]  w_grant;
  logic [SRC_W-1:0]    w_gnt_idx;
  logic [SRC_W-1:0]    w_scan;
  logic                w_gnt_any;
  logic [DATA_W-1:0]   w_sel_data;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic                w_slot_free;
  logic                w_xfer;
  logic                w_discard;
  logic                w_drain;

  // First valid source scanning upward from the pointer, wrapping; the
  // pointer never moves in fixed-priority mode, so index 0 wins there.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    w_scan    = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_scan = SRC_W'((32'(r_ptr) + k) % NUM_SRC);
      if (!w_gnt_any && src_valid[w_scan]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
    if (w_gnt_any) w_grant[w_gnt_idx] = 1'b1;
  end

  // Payload of the granted source
  always_comb begin
    w_sel_data = '0;
    w_sel_addr = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (w_grant[i]) begin
        w_sel_data = src_data[i*DATA_W +: DATA_W];
        w_sel_addr = src_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign w_slot_free = (r_state == S_EMPTY) || wb_ready;
  assign w_xfer      = w_gnt_any && w_slot_free && !flush && rst_n;
  assign src_ready   = w_grant & {NUM_SRC{w_xfer}};
  assign w_discard   = (ZERO_DISCARD != 0) && (w_sel_addr == '0);
  assign w_drain     = (r_state == S_FULL) && wb_ready;

  // Slot next-state: flush drops the pending write; drain and refill may coincide
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_src_nxt   = r_src;
    w_count_nxt = r_count;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      if (w_drain) begin
        w_state_nxt = S_EMPTY;
        w_count_nxt = r_count + CNT_W'(1);
      end
      if (w_xfer) begin
        if (RR_MODE != 0) begin
          w_ptr_nxt = (w_gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : w_gnt_idx + SRC_W'(1);
        end
        if (!w_discard) begin
          w_state_nxt = S_FULL;
          w_addr_nxt  = w_sel_addr;
          w_data_nxt  = w_sel_data;
          w_src_nxt   = w_gnt_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_src   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_src   <= w_src_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign wb_valid = (r_state == S_FULL);
  assign wb_addr  = r_addr;
  assign wb_data  = r_data;
  assign wb_src   = r_src;
  assign wb_count = r_count;

endmodule
